// File: rtl/time_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_pkg
// Shared types and constants for the single-button mm:ss time-setting front end.
//   mode_e        : operating mode of the setter (run / edit minutes / edit seconds)
//   MAX_MINSEC    : largest legal minutes or seconds value
//   MASK_MIN/SEC  : blink masks over {HEX3,HEX2,HEX1,HEX0} for the field being edited
//   incWrap       : +1 with wrap from 59 back to 0 (no carry into the other field)
//   captureMinSec : sanitises a captured counter value (anything above 59 becomes 0)
// -----------------------------------------------------------------------------
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2
  } mode_e;

  localparam logic [5:0] MAX_MINSEC = 6'd59;

  localparam logic [3:0] MASK_MIN = 4'b1100;
  localparam logic [3:0] MASK_SEC = 4'b0011;

  // Each field wraps on its own so editing seconds never disturbs minutes.
  function automatic logic [5:0] incWrap(input logic [5:0] v);
    return (v == MAX_MINSEC) ? 6'd0 : v + 6'd1;
  endfunction

  // The time counter could in principle present an out-of-range value;
  // start editing from 0 rather than from garbage.
  function automatic logic [5:0] captureMinSec(input logic [5:0] v);
    return (v > MAX_MINSEC) ? 6'd0 : v;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_if
// Bundle between the time-setting controller and the mm:ss time counter /
// display path.
//   cur_min, cur_sec : current time from the counter (0..59)
//   run_en           : 1 = counter may advance, 0 while editing
//   load             : one-cycle strobe, counter loads load_min/load_sec
//   load_min/sec     : value to load, held between strobes
//   blink_mask       : 1 = blank that digit {HEX3,HEX2,HEX1,HEX0}
//   mode             : current mode_e of the controller
// Modports: master = controller side, slave = counter/display side.
// -----------------------------------------------------------------------------
interface time_set_ctrl_if;
  import time_set_ctrl_pkg::*;

  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       run_en;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [3:0] blink_mask;
  mode_e      mode;

  modport master (
    input  cur_min, cur_sec,
    output run_en, load, load_min, load_sec, blink_mask, mode
  );

  modport slave (
    output cur_min, cur_sec,
    input  run_en, load, load_min, load_sec, blink_mask, mode
  );

endinterface

// File: rtl/time_set_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser followed by a counter-based debouncer for an
// active-low pushbutton. Also suitable for conditioning the reset key.
//   i_clk     : system clock
//   i_reset   : synchronous active-high reset (output reads released)
//   i_key_n   : raw asynchronous pushbutton, active-low
//   o_pressed : debounced, active-high "button is held"
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_pressed
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreeing cycle restarts it, so a glitch must persist
  // for DEBOUNCE_CYC consecutive cycles before it is believed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pressed = ~r_level;

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Single-button time setter for the mm:ss clock. A long press walks
// RUN -> SET_MIN -> SET_SEC -> RUN; a short press bumps the field being
// edited. Edits happen on a shadow copy that is written back to the time
// counter with a one-cycle load strobe on the way back to RUN.
//   CLOCK_50 : system clock, sole clock domain
//   reset    : synchronous active-high reset
//   key_n    : raw active-low pushbutton (KEY[1])
//   bus      : time_set_ctrl_if.master (cur time in; run_en, load,
//              load_min/sec, blink_mask, mode out)
// -----------------------------------------------------------------------------
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int BLINK_CYC    = 12_500_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_n,
  time_set_ctrl_if.master   bus
);

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYC);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic          w_pressed;
  logic [HW-1:0] r_holdCnt;
  logic          w_longEvt;
  logic          w_shortEvt;

  mode_e         r_mode;
  logic          r_runEn;
  logic          r_load;
  logic [5:0]    r_loadMin;
  logic [5:0]    r_loadSec;
  logic [5:0]    r_shMin;
  logic [5:0]    r_shSec;

  mode_e         w_modeNxt;
  logic          w_runEnNxt;
  logic          w_loadNxt;
  logic [5:0]    w_loadMinNxt;
  logic [5:0]    w_loadSecNxt;
  logic [5:0]    w_shMinNxt;
  logic [5:0]    w_shSecNxt;

  logic [BW-1:0] r_blinkCnt;
  logic          r_phase;
  logic          w_enterSet;
  logic [3:0]    w_blinkMask;

  key_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_keyDebounce (
    .i_clk     (CLOCK_50),
    .i_reset   (reset),
    .i_key_n   (key_n),
    .o_pressed (w_pressed)
  );

  // Hold counter: counts cycles of the current press, parks at LONG_CYC so it
  // cannot wrap, and clears on the first released cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_holdCnt <= '0;
    end else if (!w_pressed) begin
      r_holdCnt <= '0;
    end else if (r_holdCnt != HOLD_SAT) begin
      r_holdCnt <= r_holdCnt + HW'(1);
    end
  end

  // The long pulse is tied to a single counter value, so saturation makes it
  // fire once per press. The hold counter is nonzero while released only on
  // the release-edge cycle; it sits at HOLD_SAT there exactly when the long
  // pulse already fired, which is what suppresses the short pulse.
  assign w_longEvt  = w_pressed && (r_holdCnt == HOLD_LAST);
  assign w_shortEvt = !w_pressed && (r_holdCnt != '0) && (r_holdCnt != HOLD_SAT);

  // Mode state plus all registered outputs and the shadow time.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_mode    <= MODE_RUN;
      r_runEn   <= 1'b1;
      r_load    <= 1'b0;
      r_loadMin <= '0;
      r_loadSec <= '0;
      r_shMin   <= '0;
      r_shSec   <= '0;
    end else begin
      r_mode    <= w_modeNxt;
      r_runEn   <= w_runEnNxt;
      r_load    <= w_loadNxt;
      r_loadMin <= w_loadMinNxt;
      r_loadSec <= w_loadSecNxt;
      r_shMin   <= w_shMinNxt;
      r_shSec   <= w_shSecNxt;
    end
  end

  // Next-state logic. cur_min/cur_sec are looked at only when leaving RUN,
  // so the counter is free to show anything while the user edits.
  always_comb begin
    w_modeNxt    = r_mode;
    w_runEnNxt   = r_runEn;
    w_loadNxt    = 1'b0;
    w_loadMinNxt = r_loadMin;
    w_loadSecNxt = r_loadSec;
    w_shMinNxt   = r_shMin;
    w_shSecNxt   = r_shSec;
    case (r_mode)
      MODE_RUN: begin
        if (w_longEvt) begin
          w_modeNxt  = MODE_SET_MIN;
          w_runEnNxt = 1'b0;
          w_shMinNxt = captureMinSec(bus.cur_min);
          w_shSecNxt = captureMinSec(bus.cur_sec);
        end
      end
      MODE_SET_MIN: begin
        if (w_longEvt) begin
          w_modeNxt = MODE_SET_SEC;
        end else if (w_shortEvt) begin
          w_shMinNxt = incWrap(r_shMin);
        end
      end
      MODE_SET_SEC: begin
        if (w_longEvt) begin
          w_modeNxt    = MODE_RUN;
          w_runEnNxt   = 1'b1;
          w_loadNxt    = 1'b1;
          w_loadMinNxt = r_shMin;
          w_loadSecNxt = r_shSec;
        end else if (w_shortEvt) begin
          w_shSecNxt = incWrap(r_shSec);
        end
      end
      default: begin
        w_modeNxt  = MODE_RUN;
        w_runEnNxt = 1'b1;
      end
    endcase
  end

  // Blink phase restarts on entry to either edit mode so the freshly selected
  // field is shown first, then flips every BLINK_CYC cycles.
  assign w_enterSet = (w_modeNxt != r_mode) && (w_modeNxt != MODE_RUN);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_enterSet || (r_mode == MODE_RUN)) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_blinkCnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + BW'(1);
    end
  end

  // Blank the edited pair of digits during the odd half-period only.
  always_comb begin
    w_blinkMask = 4'b0000;
    if (r_phase) begin
      case (r_mode)
        MODE_SET_MIN: w_blinkMask = MASK_MIN;
        MODE_SET_SEC: w_blinkMask = MASK_SEC;
        default:      w_blinkMask = 4'b0000;
      endcase
    end
  end

  assign bus.mode       = r_mode;
  assign bus.run_en     = r_runEn;
  assign bus.load       = r_load;
  assign bus.load_min   = r_loadMin;
  assign bus.load_sec   = r_loadSec;
  assign bus.blink_mask = w_blinkMask;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed-plus-random bench for time_set_ctrl with short timing parameters.
// The reference keeps the user-visible state at press level (mode, shadow
// time, last loaded time) and derives event timing from the key waveform:
// a press held N cycles is seen as N debounced cycles, delayed by two
// synchroniser stages plus the debounce window.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int DEBOUNCE_CYC = 4;
  localparam int LONG_CYC     = 20;
  localparam int BLINK_CYC    = 8;

  // Cycle (counted from the key going low) whose edge makes a long press
  // visible, and offset after release for a short press.
  localparam int SYNC_LAT  = 2;
  localparam int LONG_LAT  = SYNC_LAT + DEBOUNCE_CYC + LONG_CYC;
  localparam int SHORT_LAT = SYNC_LAT + DEBOUNCE_CYC + 1;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic key_n;

  int curMin;
  int curSec;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int loadCount   = 0;

  int mMode;
  int mShMin;
  int mShSec;
  int mLoadMin;
  int mLoadSec;
  int mEntryCyc;
  int mLoadCount = 0;
  bit mLoadNow;

  time_set_ctrl_if bus ();

  assign bus.cur_min = 6'(curMin);
  assign bus.cur_sec = 6'(curSec);

  time_set_ctrl #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_CYC     (LONG_CYC),
    .BLINK_CYC    (BLINK_CYC)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_n),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Independent tally of load strobes, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (bus.load === 1'b1) loadCount++;
  end

  function automatic int nextVal(input int v);
    return (v == 59) ? 0 : v + 1;
  endfunction

  function automatic int captureVal(input int v);
    return (v > 59) ? 0 : v;
  endfunction

  function automatic int expectedMask();
    int phase;
    if (mMode == 0) return 0;
    phase = ((cyc - mEntryCyc) / BLINK_CYC) % 2;
    if (phase == 0) return 0;
    return (mMode == 1) ? 4'b1100 : 4'b0011;
  endfunction

  task automatic modelReset();
    mMode    = 0;
    mShMin   = 0;
    mShSec   = 0;
    mLoadMin = 0;
    mLoadSec = 0;
    mLoadNow = 1'b0;
    mEntryCyc = cyc;
  endtask

  task automatic modelLong();
    case (mMode)
      0: begin
        mMode     = 1;
        mShMin    = captureVal(curMin);
        mShSec    = captureVal(curSec);
        mEntryCyc = cyc;
      end
      1: begin
        mMode     = 2;
        mEntryCyc = cyc;
      end
      default: begin
        mMode    = 0;
        mLoadMin = mShMin;
        mLoadSec = mShSec;
        mLoadNow = 1'b1;
        mLoadCount++;
      end
    endcase
  endtask

  task automatic modelShort();
    if (mMode == 1) mShMin = nextVal(mShMin);
    else if (mMode == 2) mShSec = nextVal(mShSec);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, "/mode"},       32'(bus.mode),       32'(mMode));
    checkOutput({ctx, "/run_en"},     32'(bus.run_en),     32'(mMode == 0));
    checkOutput({ctx, "/load"},       32'(bus.load),       32'(mLoadNow));
    checkOutput({ctx, "/load_min"},   32'(bus.load_min),   32'(mLoadMin));
    checkOutput({ctx, "/load_sec"},   32'(bus.load_sec),   32'(mLoadSec));
    checkOutput({ctx, "/blink_mask"}, 32'(bus.blink_mask), 32'(expectedMask()));
  endtask

  // Hold the key low for holdCyc cycles, then release for gapCyc cycles,
  // checking every output on every cycle against the model.
  task automatic applyStimulus(input string ctx, input int holdCyc, input int gapCyc);
    bit isLong;
    bit isShort;
    isLong  = (holdCyc >= LONG_CYC);
    isShort = (holdCyc >= DEBOUNCE_CYC) && !isLong;
    key_n = 1'b0;
    for (int i = 1; i <= holdCyc + gapCyc; i++) begin
      tick();
      if (i == holdCyc) key_n = 1'b1;
      mLoadNow = 1'b0;
      if (isLong && i == LONG_LAT) modelLong();
      if (isShort && i == holdCyc + SHORT_LAT) modelShort();
      checkAll(ctx);
      // Once editing, the counter side may wander; the setter must ignore it.
      if (mMode != 0) begin
        curMin = $urandom_range(0, 63);
        curSec = $urandom_range(0, 63);
      end
    end
  endtask

  task automatic shortPress(input string ctx);
    applyStimulus(ctx, $urandom_range(DEBOUNCE_CYC, LONG_CYC - 1), $urandom_range(8, 12));
  endtask

  task automatic longPress(input string ctx);
    applyStimulus(ctx, $urandom_range(LONG_CYC, 40), $urandom_range(8, 12));
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    key_n  = 1'b1;
    curMin = 0;
    curSec = 0;
    modelReset();
    tick();
    tick();
    checkAll("reset");
    reset = 1'b0;

    $display("[TB] glitch rejection");
    for (int k = 0; k < 5; k++) applyStimulus("glitch2", 2, 2);
    for (int k = 0; k < 6; k++)
      applyStimulus("glitchR", $urandom_range(1, DEBOUNCE_CYC - 1), $urandom_range(1, 6));
    checkOutput("glitch_no_load", 32'(loadCount), 32'd0);

    $display("[TB] enter SET_MIN from 12:34 and edit");
    curMin = 12;
    curSec = 34;
    applyStimulus("enter_min", 30, 34);
    for (int k = 0; k < 3; k++) applyStimulus("short_min", 8, 10);
    applyStimulus("enter_sec", LONG_CYC, 20);
    for (int k = 0; k < 2; k++) applyStimulus("short_sec", 8, 10);
    applyStimulus("commit", LONG_CYC + 2, 12);
    checkOutput("commit_load_min", 32'(bus.load_min), 32'd15);
    checkOutput("commit_load_sec", 32'(bus.load_sec), 32'd36);
    checkOutput("commit_pulses", 32'(loadCount), 32'd1);

    $display("[TB] minute wrap, out-of-range capture, very long hold");
    curMin = 59;
    curSec = 63;
    applyStimulus("enter_min59", LONG_CYC + 4, 12);
    applyStimulus("wrap_min", 8, 10);
    applyStimulus("hold60", 60, 12);
    checkOutput("hold60_mode", 32'(bus.mode), 32'd2);
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) shortPress("rand_sec");

    $display("[TB] reset while editing");
    reset = 1'b1;
    tick();
    modelReset();
    checkAll("mid_reset");
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkAll("post_reset");
    end

    $display("[TB] seconds wrap without carry");
    curMin = 30;
    curSec = 58;
    longPress("nc_enter_min");
    longPress("nc_enter_sec");
    for (int k = 0; k < 2; k++) shortPress("nc_short_sec");
    longPress("nc_commit");
    checkOutput("nc_load_min", 32'(bus.load_min), 32'd30);
    checkOutput("nc_load_sec", 32'(bus.load_sec), 32'd0);

    $display("[TB] random edit rounds");
    for (int r = 0; r < 4; r++) begin
      curMin = $urandom_range(0, 63);
      curSec = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) shortPress("rand_run_short");
      longPress("rand_enter_min");
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) shortPress("rand_short_min");
      longPress("rand_enter_sec");
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) shortPress("rand_short_sec");
      longPress("rand_commit");
    end

    checkOutput("total_load_pulses", 32'(loadCount), 32'(mLoadCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
